// File: rtl/axioma_io_bitop_arbiter.sv
// Two-requester round-robin sequencer for the GPIO io_* bus: byte read, byte write, atomic bit set/clear.
// Latency: read/write respond at T+2, set/clear at T+3 (CLR on PIN at T+2); no responder backpressure.
module axioma_io_bitop_arbiter #(
  parameter logic [5:0] PINB_ADDR = 6'h23,
  parameter logic [5:0] PINC_ADDR = 6'h26,
  parameter logic [5:0] PIND_ADDR = 6'h29
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [5:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic [2:0] req0_bit,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  output logic       rsp0_bit,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [5:0] req1_addr,
  input  logic [7:0] req1_wdata,
  input  logic [2:0] req1_bit,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic       rsp1_bit,
  output logic [5:0] io_addr,
  output logic [7:0] io_data_in,
  input  logic [7:0] io_data_out,
  output logic       io_read,
  output logic       io_write,
  output logic       busy,
  output logic       owner
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last;
  logic       r_owner;
  logic [1:0] r_op;
  logic [5:0] r_addr;
  logic [2:0] r_bit;
  logic [7:0] r_rbyte;
  logic [7:0] r_wbyte;

  logic       w_grant0;
  logic       w_grant1;
  logic       w_accept;
  logic [1:0] w_sel_op;
  logic       w_is_pin;
  logic       w_pin_clr;
  logic [7:0] w_mask;
  logic [7:0] w_mod_byte;
  logic [7:0] w_rdata;

  // On a tie the requester that did not win last time gets the bus.
  assign w_grant0 = req0_valid & (~req1_valid | r_last);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last);
  assign w_accept = (r_state == ST_IDLE) & (w_grant0 | w_grant1);
  assign w_sel_op = w_grant1 ? req1_op : req0_op;

  assign w_is_pin  = (r_addr == PINB_ADDR) | (r_addr == PINC_ADDR) | (r_addr == PIND_ADDR);
  assign w_pin_clr = w_is_pin & (r_op == OP_CLR);
  assign w_mask    = 8'b1 << r_bit;

  // PIN registers toggle on write, so SET writes only the target bit.
  always_comb begin
    w_mod_byte = io_data_out & ~w_mask;
    if (r_op == OP_SET) begin
      w_mod_byte = w_is_pin ? w_mask : (io_data_out | w_mask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    io_addr     = 6'd0;
    io_data_in  = 8'd0;
    io_read     = 1'b0;
    io_write    = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = reset_n & w_grant0;
        req1_ready = reset_n & w_grant1;
        if (w_grant0 | w_grant1) begin
          w_state_nxt = (w_sel_op == OP_WRITE) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        io_read     = 1'b1;
        io_addr     = r_addr;
        w_state_nxt = ((r_op == OP_READ) | w_pin_clr) ? ST_RESP : ST_WRITE;
      end
      ST_WRITE: begin
        io_write    = 1'b1;
        io_addr     = r_addr;
        io_data_in  = r_wbyte;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid  = ~r_owner;
        rsp1_valid  = r_owner;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_op    <= OP_READ;
      r_addr  <= 6'd0;
      r_bit   <= 3'd0;
      r_rbyte <= 8'd0;
      r_wbyte <= 8'd0;
    end else begin
      if (w_accept) begin
        r_op    <= w_sel_op;
        r_addr  <= w_grant1 ? req1_addr : req0_addr;
        r_bit   <= w_grant1 ? req1_bit : req0_bit;
        r_owner <= w_grant1;
        r_last  <= w_grant1;
        if (w_sel_op == OP_WRITE) begin
          r_wbyte <= w_grant1 ? req1_wdata : req0_wdata;
        end
      end
      if (r_state == ST_READ) begin
        r_rbyte <= io_data_out;
        if ((r_op != OP_READ) && !w_pin_clr) begin
          r_wbyte <= w_mod_byte;
        end
      end
    end
  end

  // A write reports the byte it wrote; everything else reports the pre-modify read.
  assign w_rdata    = (r_op == OP_WRITE) ? r_wbyte : r_rbyte;
  assign rsp0_rdata = rsp0_valid ? w_rdata : 8'd0;
  assign rsp1_rdata = rsp1_valid ? w_rdata : 8'd0;
  assign rsp0_bit   = rsp0_valid & w_rdata[r_bit];
  assign rsp1_bit   = rsp1_valid & w_rdata[r_bit];
  assign busy       = (r_state != ST_IDLE);
  assign owner      = r_owner;

endmodule

// File: tb/tb_axioma_io_bitop_arbiter.sv
// Directed bench for axioma_io_bitop_arbiter with a small GPIO register-file model.
module tb_axioma_io_bitop_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
  logic [5:0] req0_addr = 6'd0, req1_addr = 6'd0;
  logic [7:0] req0_wdata = 8'd0, req1_wdata = 8'd0;
  logic [2:0] req0_bit = 3'd0, req1_bit = 3'd0;
  logic       rsp0_valid, rsp1_valid, rsp0_bit, rsp1_bit;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [5:0] io_addr;
  logic [7:0] io_data_in, io_data_out;
  logic       io_read, io_write, busy, owner;

  int n_run = 0;
  int n_fail = 0;
  int err_dual = 0, err_own = 0, err_idle = 0, rsp_cnt = 0;

  logic [7:0] mem [0:63];
  logic       pk_en = 1'b0;
  logic [5:0] pk_addr = 6'd0;
  logic [7:0] pk_dat = 8'd0;

  axioma_io_bitop_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_bit(req0_bit),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_bit(rsp0_bit),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_bit(req1_bit),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_bit(rsp1_bit),
    .io_addr(io_addr), .io_data_in(io_data_in), .io_data_out(io_data_out),
    .io_read(io_read), .io_write(io_write), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // GPIO model: PIN addresses toggle the PORT register two addresses above.
  assign io_data_out = mem[io_addr];
  always @(posedge clk) begin
    if (pk_en) begin
      mem[pk_addr] = pk_dat;
    end else if (io_write) begin
      if (io_addr == 6'h23 || io_addr == 6'h26 || io_addr == 6'h29)
        mem[io_addr + 6'd2] = mem[io_addr + 6'd2] ^ io_data_in;
      else
        mem[io_addr] = io_data_in;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (io_read && io_write) err_dual++;
      if ((rsp0_valid && owner) || (rsp1_valid && !owner) || (rsp0_valid && rsp1_valid)) err_own++;
      if (!io_read && !io_write && (io_addr != 6'd0 || io_data_in != 8'd0)) err_idle++;
      rsp_cnt += int'(rsp0_valid) + int'(rsp1_valid);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [5:0] a, input logic [7:0] d);
    pk_en = 1'b1; pk_addr = a; pk_dat = d;
    cyc();
    pk_en = 1'b0;
  endtask

  task automatic req(input int r, input logic [1:0] op, input logic [5:0] a,
                     input logic [7:0] d, input logic [2:0] b);
    if (r == 0) begin
      req0_op = op; req0_addr = a; req0_wdata = d; req0_bit = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_addr = a; req1_wdata = d; req1_bit = b; req1_valid = 1'b1;
    end
  endtask

  task automatic drop();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  logic exp_r;
  int   rsp_before;

  initial begin
    // Reset state, with a request pending.
    repeat (2) cyc();
    req(0, 2'b00, 6'h24, 8'h00, 3'd0);
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_io", {io_read, io_write, io_addr, io_data_in}, 0);
    check("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_rdata, owner}, 0);
    drop();
    @(negedge clk) reset_n = 1'b1;
    cyc();

    // req0 SET bit 7 @DDRB=0x0F
    poke(6'h24, 8'h0F);
    req(0, 2'b10, 6'h24, 8'h00, 3'd7);
    #1;
    check("set_ready0", {req0_ready, req1_ready}, 2'b10);
    cyc(); drop();
    check("set_t1_read", {io_read, io_write, io_addr}, {2'b10, 6'h24});
    check("set_t1_busy", {busy, owner}, 2'b10);
    cyc();
    check("set_t2_write", {io_read, io_write, io_addr}, {2'b01, 6'h24});
    check("set_t2_data", io_data_in, 8'h8F);
    cyc();
    check("set_t3_rsp", {rsp0_valid, rsp1_valid, rsp0_rdata, rsp0_bit}, {2'b10, 8'h0F, 1'b0});
    cyc();
    check("set_done", {busy, mem[6'h24]}, {1'b0, 8'h8F});

    // req1 CLR bit 0 @PORTB=0x01
    poke(6'h25, 8'h01);
    req(1, 2'b11, 6'h25, 8'h00, 3'd0);
    #1;
    check("clr_ready1", {req0_ready, req1_ready}, 2'b01);
    cyc(); drop();
    check("clr_t1_read", {io_read, owner}, 2'b11);
    cyc();
    check("clr_t2_write", {io_write, io_data_in}, {1'b1, 8'h00});
    cyc();
    check("clr_t3_rsp", {rsp1_valid, rsp0_valid, rsp1_rdata, rsp1_bit}, {2'b10, 8'h01, 1'b1});
    cyc();

    // SET and CLR on PINB
    poke(6'h23, 8'h44);
    poke(6'h25, 8'h00);
    req(0, 2'b10, 6'h23, 8'h00, 3'd2);
    cyc(); drop();
    cyc();
    check("pin_set_write", {io_write, io_addr, io_data_in}, {1'b1, 6'h23, 8'h04});
    cyc();
    check("pin_set_rsp", {rsp0_valid, rsp0_rdata, rsp0_bit}, {1'b1, 8'h44, 1'b1});
    cyc();
    check("pin_set_portb", mem[6'h25], 8'h04);
    req(0, 2'b11, 6'h23, 8'h00, 3'd2);
    cyc(); drop();
    check("pin_clr_t1", {io_read, io_write}, 2'b10);
    cyc();
    check("pin_clr_t2", {io_write, rsp0_valid, rsp0_rdata, rsp0_bit}, {2'b01, 8'h44, 1'b1});
    cyc();
    check("pin_clr_idle", {busy, mem[6'h25]}, {1'b0, 8'h04});

    // Both requesters write continuously; req0 went last, so req1 leads.
    req(0, 2'b01, 6'h30, 8'h11, 3'd0);
    req(1, 2'b01, 6'h31, 8'h22, 3'd0);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_r = (i % 2 == 0);
      check("rr_grant", {req1_ready, req0_ready}, {exp_r, ~exp_r});
      cyc();
      if (i == 3) drop();
      check("rr_write", {io_write, io_addr}, {1'b1, exp_r ? 6'h31 : 6'h30});
      cyc();
      check("rr_rsp", {rsp1_valid, rsp0_valid, owner}, {exp_r, ~exp_r, exp_r});
      cyc();
    end
    check("rr_mem", {mem[6'h30], mem[6'h31], busy}, {8'h11, 8'h22, 1'b0});

    // req0 read PIND, then req0 byte write
    poke(6'h29, 8'hA5);
    req(0, 2'b00, 6'h29, 8'h00, 3'd5);
    cyc(); drop();
    check("rd_t1", {io_read, io_write, io_addr}, {2'b10, 6'h29});
    cyc();
    check("rd_t2_rsp", {rsp0_valid, rsp0_rdata, rsp0_bit}, {1'b1, 8'hA5, 1'b1});
    cyc();
    req(0, 2'b01, 6'h2A, 8'h3C, 3'd2);
    cyc(); drop();
    check("wr_t1", {io_read, io_write, io_data_in}, {2'b01, 8'h3C});
    cyc();
    check("wr_t2_rsp", {rsp0_valid, rsp0_rdata, rsp0_bit}, {1'b1, 8'h3C, 1'b1});
    cyc();
    check("wr_mem", mem[6'h2A], 8'h3C);

    // Reset asserted during the WRITE of a SET
    req(0, 2'b10, 6'h24, 8'h00, 3'd4);
    cyc(); drop();
    cyc();
    check("rst_pre_write", {io_write, io_data_in}, {1'b1, 8'h9F});
    rsp_before = rsp_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_async_io", {io_read, io_write, io_addr, io_data_in}, 0);
    check("rst_async_st", {busy, owner, rsp0_valid, rsp1_valid}, 0);
    repeat (3) cyc();
    @(negedge clk) reset_n = 1'b1;
    repeat (3) cyc();
    check("rst_no_rsp", rsp_cnt, rsp_before);
    check("rst_no_write", mem[6'h24], 8'h8F);
    req(0, 2'b00, 6'h24, 8'h00, 3'd0);
    req(1, 2'b00, 6'h25, 8'h00, 3'd0);
    #1;
    check("rst_first_tie", {req0_ready, req1_ready}, 2'b10);
    cyc(); drop();
    cyc();
    check("rst_tie_rsp", {rsp0_valid, rsp0_rdata}, {1'b1, 8'h8F});
    cyc();

    check("no_dual_strobe", err_dual, 0);
    check("rsp_matches_owner", err_own, 0);
    check("bus_idle_zero", err_idle, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
